// File: rtl/sramlike_arbiter_pkg.sv
// Shared types for the SRAM-like 2:1 arbiter: FSM state encoding and transfer size codes.
package sramlike_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
endpackage

// File: rtl/sramlike_arbiter_pick.sv
// 2-way selector for the arbiter: fixed data priority, or round-robin on ties
// when SRAMLIKE_ARB_ROUND_ROBIN_EN is defined.
module arb_pick (
  input  logic inst_req,
  input  logic data_req,
`ifdef SRAMLIKE_ARB_ROUND_ROBIN_EN
  input  logic last_data,
`endif
  output logic gnt_i,
  output logic gnt_d
);
  always_comb begin
    gnt_d = data_req;
    gnt_i = inst_req & ~data_req;
`ifdef SRAMLIKE_ARB_ROUND_ROBIN_EN
    // On a tie, whoever was not granted last wins.
    if (inst_req && data_req) begin
      gnt_d = ~last_data;
      gnt_i = last_data;
    end
`endif
  end
endmodule

// File: rtl/sramlike_arbiter.sv
// Arbitrates an inst and a data SRAM-like master onto one slave, one transaction in flight.
// Define SRAMLIKE_ARB_ROUND_ROBIN_EN for round-robin tie breaking instead of data priority.
module sramlike_arbiter
  import sramlike_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy
);
  arb_state_e state;
  logic       sel_lock, sel_q, busy_q;
  logic       gnt_i, gnt_d, sel_data, sel_req, hs;
`ifdef SRAMLIKE_ARB_ROUND_ROBIN_EN
  logic       last_data;
`endif

  arb_pick u_pick (
    .inst_req (inst_req),
    .data_req (data_req),
`ifdef SRAMLIKE_ARB_ROUND_ROBIN_EN
    .last_data(last_data),
`endif
    .gnt_i    (gnt_i),
    .gnt_d    (gnt_d)
  );

  // A locked selection follows its owner's req only; dropping it frees the lock.
  always_comb begin
    sel_data = sel_lock ? sel_q : gnt_d;
    sel_req  = sel_lock ? (sel_q ? data_req : inst_req) : (gnt_i | gnt_d);
  end

  assign req   = !rst && (state == IDLE) && sel_req;
  assign wr    = req && (sel_data ? data_wr : inst_wr);
  assign size  = req ? (sel_data ? data_size  : inst_size)  : '0;
  assign addr  = req ? (sel_data ? data_addr  : inst_addr)  : '0;
  assign wdata = req ? (sel_data ? data_wdata : inst_wdata) : '0;
  assign hs    = req && addr_ok;

  assign inst_addr_ok = hs && !sel_data;
  assign data_addr_ok = hs && sel_data;
  assign inst_data_ok = !rst && (state == WAIT_I) && data_ok;
  assign data_data_ok = !rst && (state == WAIT_D) && data_ok;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign busy         = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_lock  <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SRAMLIKE_ARB_ROUND_ROBIN_EN
      last_data <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            state     <= sel_data ? WAIT_D : WAIT_I;
            busy_q    <= 1'b1;
            sel_lock  <= 1'b0;
`ifdef SRAMLIKE_ARB_ROUND_ROBIN_EN
            last_data <= sel_data;
`endif
          end else if (req) begin
            sel_lock <= 1'b1;
            sel_q    <= sel_data;
          end else begin
            sel_lock <= 1'b0;
          end
        end
        WAIT_I, WAIT_D: begin
          if (data_ok) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: transaction-level model compared every cycle plus directed literal checks.
// Honours SRAMLIKE_ARB_ROUND_ROBIN_EN for the tie-break expectations.
module tb_sramlike_arbiter;
  import sramlike_arbiter_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0, rst = 1'b1;
  logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0] inst_size = 0, data_size = 0;
  logic [AW-1:0] inst_addr = 0, data_addr = 0;
  logic [DW-1:0] inst_wdata = 0, data_wdata = 0, rdata = 0;
  logic addr_ok = 0, data_ok = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, req, wr, busy;
  logic [1:0] size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, inst_rdata, data_rdata;

  int checks = 0, errors = 0;
  bit chk_en = 0;
  int n_iaok = 0, n_idok = 0, n_daok = 0, n_ddok = 0;

  always #5 clk = ~clk;

  sramlike_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .busy(busy)
  );

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  // Model: who owns the slave (pending 0 none / 1 inst / 2 data), who holds
  // a stalled address phase, and who was granted last.
  int m_pend = 0, m_own = 0, m_last = 1;

  always @(negedge clk) if (chk_en) begin
    int who;
    logic wreq, e_wr, e_iaok, e_daok, e_idok, e_ddok;
    logic [1:0] e_size;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    who = 0; wreq = 0; e_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
    e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0;
    if (!rst) begin
      if (m_pend == 0) begin
        if (m_own != 0) who = m_own;
        else if (inst_req && data_req) begin
`ifdef SRAMLIKE_ARB_ROUND_ROBIN_EN
          who = (m_last == 1) ? 2 : 1;
`else
          who = 2;
`endif
        end else if (data_req) who = 2;
        else if (inst_req) who = 1;
        wreq = (who == 2) ? data_req : (who == 1) ? inst_req : 1'b0;
        if (wreq) begin
          e_wr    = (who == 2) ? data_wr    : inst_wr;
          e_size  = (who == 2) ? data_size  : inst_size;
          e_addr  = (who == 2) ? data_addr  : inst_addr;
          e_wdata = (who == 2) ? data_wdata : inst_wdata;
        end
        e_iaok = wreq && addr_ok && who == 1;
        e_daok = wreq && addr_ok && who == 2;
      end else begin
        e_idok = data_ok && m_pend == 1;
        e_ddok = data_ok && m_pend == 2;
      end
    end
    chk("m_req", {63'd0, req}, {63'd0, wreq});
    chk("m_wr", {63'd0, wr}, {63'd0, e_wr});
    chk("m_size", {62'd0, size}, {62'd0, e_size});
    chk("m_addr", {32'd0, addr}, {32'd0, e_addr});
    chk("m_wdata", {32'd0, wdata}, {32'd0, e_wdata});
    chk("m_inst_addr_ok", {63'd0, inst_addr_ok}, {63'd0, e_iaok});
    chk("m_data_addr_ok", {63'd0, data_addr_ok}, {63'd0, e_daok});
    chk("m_inst_data_ok", {63'd0, inst_data_ok}, {63'd0, e_idok});
    chk("m_data_data_ok", {63'd0, data_data_ok}, {63'd0, e_ddok});
    chk("m_inst_rdata", {32'd0, inst_rdata}, {32'd0, rdata});
    chk("m_data_rdata", {32'd0, data_rdata}, {32'd0, rdata});
    chk("m_busy", {63'd0, busy}, {63'd0, m_pend != 0});
    if (rst) begin
      m_pend = 0; m_own = 0; m_last = 1;
    end else if (m_pend == 0) begin
      if (wreq && addr_ok) begin m_pend = who; m_own = 0; m_last = who; end
      else if (wreq) m_own = who;
      else m_own = 0;
    end else if (data_ok) m_pend = 0;
  end

  always @(negedge clk) begin
    if (inst_addr_ok === 1'b1) n_iaok++;
    if (inst_data_ok === 1'b1) n_idok++;
    if (data_addr_ok === 1'b1) n_daok++;
    if (data_data_ok === 1'b1) n_ddok++;
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic settle(); #2; endtask

  initial begin
    int a0, b0, c0, d0;
    // Reset
    cyc(); chk_en = 1;
    cyc(); settle();
    chk("rst_req", {63'd0, req}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 0;

    // Case 1: inst-only read
    cyc();
    a0 = n_iaok; b0 = n_idok; c0 = n_daok; d0 = n_ddok;
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = SIZE_W; addr_ok = 1;
    settle();
    chk("c1_addr", {32'd0, addr}, 64'hBFC0_0000);
    chk("c1_inst_addr_ok", {63'd0, inst_addr_ok}, 64'd1);
    cyc(); inst_req = 0; addr_ok = 0; settle();
    chk("c1_busy", {63'd0, busy}, 64'd1);
    cyc(); cyc(); cyc();
    data_ok = 1; rdata = 32'h2408_0001; settle();
    chk("c1_inst_data_ok", {63'd0, inst_data_ok}, 64'd1);
    chk("c1_inst_rdata", {32'd0, inst_rdata}, 64'h2408_0001);
    cyc(); data_ok = 0; settle();
    chk("c1_busy_done", {63'd0, busy}, 64'd0);
    chk("c1_pulses", {32'(n_iaok - a0), 32'(n_idok - b0)}, {32'd1, 32'd1});
    chk("c1_data_quiet", {32'(n_daok - c0), 32'(n_ddok - d0)}, 64'd0);

    // Case 2: simultaneous requests, data first, inst after one bubble
    cyc();
    inst_req = 1; inst_addr = 32'h1FC0_0004; data_req = 1; data_addr = 32'h8000_0010; addr_ok = 1;
    settle();
    chk("c2_addr_first", {32'd0, addr}, 64'h8000_0010);
    chk("c2_inst_aok_blocked", {63'd0, inst_addr_ok}, 64'd0);
    cyc(); data_req = 0; addr_ok = 0;
    cyc(); data_ok = 1; rdata = 32'h1234_5678; settle();
    chk("c2_bubble_req", {63'd0, req}, 64'd0);
    cyc(); data_ok = 0; addr_ok = 1; settle();
    chk("c2_inst_second", {32'd0, addr}, 64'h1FC0_0004);
    cyc(); inst_req = 0; addr_ok = 0;
    cyc(); data_ok = 1;
    cyc(); data_ok = 0;
    // Tie again after a data grant: round-robin flips to inst
    inst_req = 1; data_req = 1; addr_ok = 1;
    cyc(); addr_ok = 0;
    cyc(); data_ok = 1;
    cyc(); data_ok = 0; addr_ok = 1; settle();
`ifdef SRAMLIKE_ARB_ROUND_ROBIN_EN
    chk("c2_tie_rr", {32'd0, addr}, 64'h1FC0_0004);
`else
    chk("c2_tie_fixed", {32'd0, addr}, 64'h8000_0010);
`endif
    cyc(); inst_req = 0; data_req = 0; addr_ok = 0;
    cyc(); data_ok = 1;
    cyc(); data_ok = 0;

    // Case 3: lock holds inst while addr_ok is low
    a0 = n_daok;
    inst_req = 1; inst_addr = 32'h0000_1000; settle();
    chk("c3_t0_addr", {32'd0, addr}, 64'h0000_1000);
    cyc(); data_req = 1; data_addr = 32'h8000_0020; settle();
    chk("c3_t1_addr", {32'd0, addr}, 64'h0000_1000);
    cyc(); addr_ok = 1; settle();
    chk("c3_t2_inst_aok", {63'd0, inst_addr_ok}, 64'd1);
    chk("c3_data_aok_none", 64'(n_daok - a0), 64'd0);
    cyc(); inst_req = 0; addr_ok = 0;
    cyc(); data_ok = 1;
    cyc(); data_ok = 0; addr_ok = 1; settle();
    chk("c3_data_after", {32'd0, addr}, 64'h8000_0020);
    cyc(); data_req = 0; addr_ok = 0;
    cyc(); data_ok = 1;
    cyc(); data_ok = 0;
    // Lock release when the owner drops req
    inst_req = 1;
    cyc(); inst_req = 0; data_req = 1; settle();
    chk("c3_rel_still_locked", {63'd0, req}, 64'd0);
    cyc(); settle();
    chk("c3_rel_data", {32'd0, addr}, 64'h8000_0020);
    addr_ok = 1;
    cyc(); data_req = 0; addr_ok = 0;
    cyc(); data_ok = 1;
    cyc(); data_ok = 0; settle();
    // Stray data_ok in IDLE
    cyc(); data_ok = 1; settle();
    chk("c3_stray_dok", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
    cyc(); data_ok = 0;

    // Case 4: byte write
    a0 = n_ddok;
    data_req = 1; data_wr = 1; data_size = SIZE_B; data_wdata = 32'h0000_00AB;
    data_addr = 32'h8000_1000; addr_ok = 1; settle();
    chk("c4_wr_size", {61'd0, wr, size}, {61'd0, 1'b1, SIZE_B});
    chk("c4_wdata", {32'd0, wdata}, 64'hAB);
    chk("c4_busy_hs", {63'd0, busy}, 64'd0);
    cyc(); data_req = 0; data_wr = 0; data_wdata = 0; addr_ok = 0; settle();
    chk("c4_busy_wait", {63'd0, busy}, 64'd1);
    chk("c4_bus_zero", {31'd0, wr, wdata}, 64'd0);
    cyc(); data_ok = 1; settle();
    chk("c4_ddok", {62'd0, busy, data_data_ok}, 64'd3);
    cyc(); data_ok = 0; settle();
    chk("c4_busy_end", {63'd0, busy}, 64'd0);
    chk("c4_ddok_once", 64'(n_ddok - a0), 64'd1);

    // Case 5: reset mid-WAIT_D then stray data_ok
    data_req = 1; data_addr = 32'h8000_2000; addr_ok = 1;
    cyc(); data_req = 0; addr_ok = 0;
    cyc(); rst = 1; data_ok = 1; settle();
    chk("c5_rst_gate", {62'd0, data_data_ok, req}, 64'd0);
    cyc(); rst = 0; settle();
    chk("c5_after_rst", {61'd0, busy, data_data_ok, inst_data_ok}, 64'd0);
    cyc(); data_ok = 0;
    inst_req = 1; inst_addr = 32'hBFC0_0100; addr_ok = 1; settle();
    chk("c5_inst_aok", {63'd0, inst_addr_ok}, 64'd1);
    cyc(); inst_req = 0; addr_ok = 0;
    cyc(); data_ok = 1; rdata = 32'hCAFE_F00D; settle();
    chk("c5_inst_dok", {32'd0, inst_rdata}, {32'd0, 32'hCAFE_F00D});
    chk("c5_inst_dok_bit", {63'd0, inst_data_ok}, 64'd1);
    cyc(); data_ok = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sramlike_arbiter.md
SRAMLIKE_ARBITER -- requirements
Module: sramlike_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width of all ports.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have inst master ports: inst_req/inst_wr in 1, inst_size in 2, inst_addr in ADDR_W, inst_wdata in DATA_W, inst_addr_ok/inst_data_ok out 1, inst_rdata out DATA_W.
REQ-006 The block SHALL have data master ports: data_req/data_wr in 1, data_size in 2, data_addr in ADDR_W, data_wdata in DATA_W, data_addr_ok/data_data_ok out 1, data_rdata out DATA_W.
REQ-007 The block SHALL have slave ports: req/wr out 1, size out 2, addr out ADDR_W, wdata out DATA_W, addr_ok/data_ok in 1, rdata in DATA_W.
REQ-008 The block SHALL have port busy, output, 1, meaning a slave transaction is outstanding.

Function
REQ-009 The FSM SHALL have states IDLE, WAIT_I, WAIT_D; at most one slave transaction outstanding.
REQ-010 In IDLE with no lock, the selector SHALL pick data over inst when both req are high (fixed priority).
REQ-011 The selected master's req/wr/size/addr/wdata SHALL drive the slave combinationally in IDLE; the unselected master's fields SHALL NOT reach the slave.
REQ-012 If the slave req is high and addr_ok is low, the selection SHALL be locked (sel_lock, sel_q registered) until addr_ok; a later-arriving higher-priority req SHALL NOT switch the selection.
REQ-013 Slave addr_ok SHALL be routed only to the selected master's *_addr_ok; the other master's *_addr_ok SHALL be 0.
REQ-014 On req && addr_ok in IDLE, the FSM SHALL go to WAIT_I or WAIT_D per selection and clear the lock.
REQ-015 In WAIT_x, the slave req SHALL be 0 and both *_addr_ok SHALL be 0.
REQ-016 In WAIT_x, slave data_ok SHALL be routed only to x_data_ok; then the FSM SHALL return to IDLE next cycle.
REQ-017 rdata SHALL be broadcast unregistered to inst_rdata and data_rdata; only *_data_ok qualifies it.
REQ-018 The next slave req SHALL be issued no earlier than the cycle after data_ok (one bubble).
REQ-019 Slave data_ok received in IDLE SHALL be ignored; no *_data_ok pulse.
REQ-020 A master dropping req while locked SHALL release the lock next cycle.
REQ-021 When the slave req is 0, wr, size, addr and wdata SHALL be 0.
REQ-022 busy SHALL be 1 exactly in WAIT_I/WAIT_D.

Reset
REQ-023 On rst: state SHALL go to IDLE, lock SHALL clear, last_grant SHALL go to inst, and busy SHALL go to 0.
REQ-024 During rst, req, *_addr_ok and *_data_ok SHALL be 0.
REQ-025 An outstanding response SHALL be dropped if reset arrives mid-transaction; any data_ok after reset SHALL fall under REQ-019.

Configuration
REQ-026 With macro SRAMLIKE_ARB_ROUND_ROBIN_EN defined, on simultaneous unlocked requests the master not granted last SHALL win; last_grant SHALL update at each addr_ok handshake.
REQ-027 Without SRAMLIKE_ARB_ROUND_ROBIN_EN, REQ-010 fixed data priority SHALL apply and no last_grant register SHALL exist.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/WAIT_I/WAIT_D) and the size constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
REQ-029 A sub-module arb_pick SHALL hold the 2-way priority/round-robin selector; the FSM and mux SHALL stay in sramlike_arbiter.

Verification
REQ-030 Case 1, inst-only read: inst_req=1, addr=0xBFC00000, addr_ok same cycle, data_ok 3 cycles later rdata=0x24080001 -> inst_addr_ok pulses once, inst_data_ok one pulse, inst_rdata=0x24080001, data_* ok stay 0.
REQ-031 Case 2, simultaneous requests: inst_req=1 and data_req=1 with data_addr=0x80000010 -> slave addr=0x80000010 first; inst served after data_ok plus one bubble; with the macro, the next tie goes to inst.
REQ-032 Case 3, lock: inst_req at t0 with addr_ok held low for 2 cycles, data_req rises at t1 -> slave addr stays inst_addr until addr_ok; data_addr_ok=0 throughout.
REQ-033 Case 4, write with wen byte: data_wr=1, size=2'b00, wdata=0x000000AB -> slave wr=1, size=2'b00; data_data_ok pulses once; busy high from addr_ok cycle+1 until data_ok.
REQ-034 Case 5, reset mid-WAIT_D followed by a stray data_ok -> no *_data_ok pulse, state IDLE, next inst request serviced normally.
